// File: rtl/wall_follower_pkg.sv
// Shared types for the wall-following controller: FSM states and motion commands.
package wall_follower_pkg;

    // FSM state, 2-bit encoding; 2'b11 is unused and recovers to SEARCH
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_FOLLOW = 2'd1,
        ST_ROTATE = 2'd2
    } state_e;

    // Motion command pair driven to the motor stage
    typedef struct packed {
        logic front;
        logic rotate;
    } motion_t;

    localparam motion_t MOT_IDLE   = '{front: 1'b0, rotate: 1'b0};
    localparam motion_t MOT_SEARCH = '{front: 1'b1, rotate: 1'b0};
    localparam motion_t MOT_FOLLOW = '{front: 1'b1, rotate: 1'b0};
    localparam motion_t MOT_ROTATE = '{front: 1'b0, rotate: 1'b1};

    // Moore output decode; unknown encodings drive the SEARCH command
    function automatic motion_t state_motion(input state_e st);
        motion_t m;
        case (st)
            ST_SEARCH: m = MOT_SEARCH;
            ST_FOLLOW: m = MOT_FOLLOW;
            ST_ROTATE: m = MOT_ROTATE;
            default:   m = MOT_SEARCH;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wall_follower_tick_gen.sv
// Decision-tick generator: one-cycle pulse every Clock_frequency clocks.
module tick_gen #(
    parameter int unsigned Clock_frequency = 6
) (
    input  logic initial_Clock,
    input  logic Reset,
    output logic tick
);

    localparam int unsigned CNT_W = (Clock_frequency > 1) ? $clog2(Clock_frequency) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Clock_frequency - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign tick   = w_last;

    // Free-running modulo counter, restarts from 0 on reset
    always_ff @(posedge initial_Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wall_follower_main.sv
// Left-hand wall-following controller: sensor sync, tick-paced Moore FSM, registered motion outputs.
module wall_follower_main
    import wall_follower_pkg::*;
#(
    parameter int unsigned Clock_frequency = 6
) (
    input  logic initial_Clock,
    input  logic Reset,
    input  logic Head,
    input  logic Left,
    output logic Front,
    output logic Rotate
);

    logic    w_tick;
    logic    r_head_s1;
    logic    r_head_s2;
    logic    r_left_s1;
    logic    r_left_s2;
    state_e  r_state;
    state_e  w_state_nxt;
    motion_t w_motion_nxt;
    motion_t r_motion;

    tick_gen #(
        .Clock_frequency(Clock_frequency)
    ) u_tick_gen (
        .initial_Clock(initial_Clock),
        .Reset        (Reset),
        .tick         (w_tick)
    );

    // Two-flop synchronisers for the asynchronous sensor inputs
    always_ff @(posedge initial_Clock or posedge Reset) begin
        if (Reset) begin
            r_head_s1 <= 1'b0;
            r_head_s2 <= 1'b0;
            r_left_s1 <= 1'b0;
            r_left_s2 <= 1'b0;
        end else begin
            r_head_s1 <= Head;
            r_head_s2 <= r_head_s1;
            r_left_s1 <= Left;
            r_left_s2 <= r_left_s1;
        end
    end

    // State register, advances only on the decision tick
    always_ff @(posedge initial_Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_SEARCH;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an obstacle ahead overrides the left wall in every state
    always_comb begin
        w_state_nxt = ST_SEARCH;
        case (r_state)
            ST_SEARCH, ST_FOLLOW, ST_ROTATE: begin
                if (r_head_s2) begin
                    w_state_nxt = ST_ROTATE;
                end else if (r_left_s2) begin
                    w_state_nxt = ST_FOLLOW;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    // Output decode of the next state, so the command lands on the same tick edge
    always_comb begin
        w_motion_nxt = MOT_IDLE;
        w_motion_nxt = state_motion(w_state_nxt);
    end

    // Motion command register; idle from reset until the first tick
    always_ff @(posedge initial_Clock or posedge Reset) begin
        if (Reset) begin
            r_motion <= MOT_IDLE;
        end else if (w_tick) begin
            r_motion <= w_motion_nxt;
        end
    end

    assign Front  = r_motion.front;
    assign Rotate = r_motion.rotate;

endmodule

// File: tb/tb_wall_follower_main.sv
// Scoreboard bench for wall_follower_main with a 6-clock decision tick.
module tb_wall_follower_main;

    logic clk = 1'b0;
    logic rst;
    logic head;
    logic left;
    logic front;
    logic rotate;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side model of the controller
    localparam int M_SEARCH = 0;
    localparam int M_FOLLOW = 1;
    localparam int M_ROTATE = 2;
    int         m_state;
    logic [1:0] m_out;   // {Front, Rotate} currently shown by the DUT

    logic [1:0] exp_q[$];
    string      tag_q[$];

    always #1 clk = ~clk;

    wall_follower_main #(
        .Clock_frequency(6)
    ) dut (
        .initial_Clock(clk),
        .Reset        (rst),
        .Head         (head),
        .Left         (left),
        .Front        (front),
        .Rotate       (rotate)
    );

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_next(input int st, input logic h, input logic l);
        if (st > M_ROTATE) return M_SEARCH;
        if (h) return M_ROTATE;
        if (l) return M_FOLLOW;
        return M_SEARCH;
    endfunction

    function automatic logic [1:0] model_out(input int st);
        return (st == M_ROTATE) ? 2'b01 : 2'b10;
    endfunction

    // Advance the model on the current inputs and queue the expected command
    task automatic push_expect(input string tag);
        m_state = model_next(m_state, head, left);
        exp_q.push_back(model_out(m_state));
        tag_q.push_back(tag);
    endtask

    task automatic pop_compare();
        logic [1:0] e;
        string      t;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 2'(exp_q.size()), 2'd1);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {front, rotate}, e);
            m_out = e;
        end
    endtask

    // Release reset at a falling edge; first tick is the 6th rising edge after
    task automatic release_and_first_tick(input string tag);
        @(negedge clk);
        rst     = 1'b0;
        m_state = M_SEARCH;
        m_out   = 2'b00;
        push_expect(tag);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check({tag, "_pre_tick_idle"}, {front, rotate}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        pop_compare();
    endtask

    // From the falling edge after a tick: change inputs mid-period, check hold, check tick result
    task automatic do_tick(input logic h, input logic l, input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        head = h;
        left = l;
        push_expect(tag);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, {front, rotate}, m_out);
        @(posedge clk);
        @(negedge clk);
        pop_compare();
    endtask

    // Pulse Head for three clocks early in the period; it must not reach the FSM
    task automatic glitch_tick(input string tag);
        head = ~head;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_during_glitch"}, {front, rotate}, m_out);
        head = ~head;
        push_expect(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_hold"}, {front, rotate}, m_out);
        @(posedge clk);
        @(negedge clk);
        pop_compare();
    endtask

    initial begin
        #40000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        head = 1'b0;
        left = 1'b0;
        m_state = M_SEARCH;
        m_out   = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {front, rotate}, 2'b00);

        release_and_first_tick("first_search");

        do_tick(1'b1, 1'b0, "search_head_rotate");
        do_tick(1'b0, 1'b0, "rotate_clear_search");
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b0, 1'b1, $sformatf("follow_%0d", i));
        end
        do_tick(1'b1, 1'b1, "follow_head_left_rotate");
        do_tick(1'b1, 1'b0, "rotate_head_rotate");
        do_tick(1'b0, 1'b0, "rotate_to_search");

        do_tick(1'b0, 1'b1, "search_to_follow");
        glitch_tick("follow_head_glitch");
        do_tick(1'b0, 1'b0, "follow_wall_lost");
        do_tick(1'b1, 1'b1, "search_both_rotate");
        do_tick(1'b0, 1'b1, "rotate_to_follow");
        do_tick(1'b1, 1'b0, "follow_to_rotate");

        // Asynchronous reset while rotating, mid-count
        repeat (3) @(posedge clk);
        rst  = 1'b1;
        head = 1'b0;
        left = 1'b0;
        @(negedge clk);
        check("reset_mid_rotate", {front, rotate}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", {front, rotate}, 2'b00);
        release_and_first_tick("after_reset_search");

        for (int i = 0; i < 10; i++) begin
            do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $sformatf("random_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
